// File: rtl/vpu_pkg.sv
// Shared definitions for the VPU sequencer: opcode map, FSM state encoding
// and the legal-opcode decode.
package vpu_pkg;

    localparam int unsigned OP_W    = 5;
    localparam int unsigned ALU_W   = 3;

    localparam logic [OP_W-1:0] OP_VADD = 5'b10000;
    localparam logic [OP_W-1:0] OP_VSUB = 5'b10001;
    localparam logic [OP_W-1:0] OP_VMUL = 5'b10010;
    localparam logic [OP_W-1:0] OP_VDOT = 5'b10011;
    localparam logic [OP_W-1:0] OP_VLD  = 5'b10100;
    localparam logic [OP_W-1:0] OP_VST  = 5'b10101;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_READ = 3'd1,
        ST_EXEC = 3'd2,
        ST_MEM  = 3'd3,
        ST_WB   = 3'd4,
        ST_DONE = 3'd5
    } vpu_state_e;

    // Anything the CPU hands us outside the six implemented ops is illegal.
    function automatic logic is_vpu_legal(input logic [OP_W-1:0] op);
        return (op inside {OP_VADD, OP_VSUB, OP_VMUL, OP_VDOT, OP_VLD, OP_VST});
    endfunction

endpackage

// File: rtl/vpu_lane_counter.sv
// Element index register and the EXEC-phase latency down-counter.
module vpu_lane_counter
    import vpu_pkg::*;
#(
    parameter int unsigned VEC_LEN = 4,
    parameter int unsigned LANE_W  = 2,
    parameter int unsigned CNT_W   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              lane_clr,
    input  logic              lane_inc,
    input  logic              cnt_load,
    input  logic [CNT_W-1:0]  cnt_val,
    input  logic              cnt_dec,
    output logic [LANE_W-1:0] lane_idx,
    output logic              lane_last_c,
    output logic              cnt_zero_c
);

    logic [CNT_W-1:0] cnt;

    assign lane_last_c = (lane_idx == LANE_W'(VEC_LEN - 1));
    assign cnt_zero_c  = (cnt == '0);

    // Lane index saturates at the final element; it never wraps mid-instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_idx <= '0;
            cnt      <= '0;
        end else begin
            if (lane_clr) begin
                lane_idx <= '0;
            end else if (lane_inc && !lane_last_c) begin
                lane_idx <= lane_idx + LANE_W'(1);
            end
            if (cnt_load) begin
                cnt <= cnt_val;
            end else if (cnt_dec && !cnt_zero_c) begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/vpu_sequencer.sv
// VPU-side sequencer: answers the CPU VPU_start/VPU_rdy handshake and walks
// each vector instruction through READ/EXEC/MEM/WB phases lane by lane.
module vpu_sequencer
    import vpu_pkg::*;
#(
    parameter int unsigned VEC_LEN = 4,
    parameter int unsigned LANE_W  = 2,
    parameter int unsigned MUL_LAT = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              VPU_start,
    input  logic [OP_W-1:0]   opcode,
    input  logic              x_bit,
    input  logic              mem_ack,
    output logic              VPU_rdy,
    output logic [LANE_W-1:0] lane_idx,
    output logic              vrf_re,
    output logic              vrf_we,
    output logic [ALU_W-1:0]  alu_op,
    output logic              op_x,
    output logic              acc_clr,
    output logic              acc_en,
    output logic              mem_req,
    output logic              mem_we,
    output logic              illegal_op
);

    localparam int unsigned CNT_W = $clog2(MUL_LAT + 1);

    vpu_state_e      state, nxt_state;
    logic [OP_W-1:0] op_q, nxt_op;
    logic            nxt_x;

    logic            lane_clr, lane_inc, cnt_load, cnt_dec;
    logic            lane_last_c, cnt_zero_c;
    logic [CNT_W-1:0] cnt_val;

    logic nxt_vrf_re, nxt_vrf_we, nxt_acc_clr, nxt_acc_en;
    logic nxt_mem_req, nxt_mem_we, nxt_illegal;

    logic is_mem_op, is_vdot;

    vpu_lane_counter #(
        .VEC_LEN (VEC_LEN),
        .LANE_W  (LANE_W),
        .CNT_W   (CNT_W)
    ) u_lane_counter (
        .clk         (clk),
        .rst_n       (rst_n),
        .lane_clr    (lane_clr),
        .lane_inc    (lane_inc),
        .cnt_load    (cnt_load),
        .cnt_val     (cnt_val),
        .cnt_dec     (cnt_dec),
        .lane_idx    (lane_idx),
        .lane_last_c (lane_last_c),
        .cnt_zero_c  (cnt_zero_c)
    );

    // Ready drops combinationally as soon as a request shows up in IDLE.
    assign VPU_rdy   = ((state == ST_IDLE) && !VPU_start) || (state == ST_DONE);
    assign alu_op    = op_q[ALU_W-1:0];
    assign is_mem_op = (op_q == OP_VLD) || (op_q == OP_VST);
    assign is_vdot   = (op_q == OP_VDOT);
    assign cnt_val   = (op_q == OP_VMUL) ? CNT_W'(MUL_LAT - 1) : '0;

    // Next-state and next-output decode; outputs are registered below.
    always_comb begin
        nxt_state = state;
        nxt_op    = op_q;
        nxt_x     = op_x;
        lane_clr  = 1'b0;
        lane_inc  = 1'b0;
        cnt_load  = 1'b0;
        cnt_dec   = 1'b0;

        case (state)
            ST_IDLE: begin
                if (VPU_start) begin
                    nxt_op    = opcode;
                    nxt_x     = x_bit;
                    lane_clr  = 1'b1;
                    nxt_state = is_vpu_legal(opcode) ? ST_READ : ST_DONE;
                end
            end
            ST_READ: begin
                if (is_mem_op) begin
                    nxt_state = ST_MEM;
                end else begin
                    nxt_state = ST_EXEC;
                    cnt_load  = 1'b1;
                end
            end
            ST_EXEC: begin
                if (!cnt_zero_c) begin
                    cnt_dec = 1'b1;
                end else if (is_vdot && !lane_last_c) begin
                    lane_inc  = 1'b1;
                    nxt_state = ST_READ;
                end else begin
                    nxt_state = ST_WB;
                end
            end
            ST_MEM: begin
                if (mem_ack) begin
                    if (op_q == OP_VLD) begin
                        nxt_state = ST_WB;
                    end else if (lane_last_c) begin
                        nxt_state = ST_DONE;
                    end else begin
                        lane_inc  = 1'b1;
                        nxt_state = ST_READ;
                    end
                end
            end
            ST_WB: begin
                if (lane_last_c) begin
                    nxt_state = ST_DONE;
                end else begin
                    lane_inc  = 1'b1;
                    nxt_state = ST_READ;
                end
            end
            ST_DONE: nxt_state = ST_IDLE;
            default: nxt_state = ST_IDLE;
        endcase

        nxt_vrf_re  = (nxt_state == ST_READ);
        nxt_vrf_we  = (nxt_state == ST_WB);
        // Lane 0 READ is only ever entered from the accept, so clear there.
        nxt_acc_clr = (state == ST_IDLE) && VPU_start && (opcode == OP_VDOT);
        nxt_acc_en  = (nxt_state == ST_EXEC) && (nxt_op == OP_VDOT);
        nxt_mem_req = (nxt_state == ST_MEM);
        nxt_mem_we  = (nxt_state == ST_MEM) && (nxt_op == OP_VST);
        nxt_illegal = (nxt_state == ST_DONE) && !is_vpu_legal(nxt_op);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            op_q       <= '0;
            op_x       <= 1'b0;
            vrf_re     <= 1'b0;
            vrf_we     <= 1'b0;
            acc_clr    <= 1'b0;
            acc_en     <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            illegal_op <= 1'b0;
        end else begin
            state      <= nxt_state;
            op_q       <= nxt_op;
            op_x       <= nxt_x;
            vrf_re     <= nxt_vrf_re;
            vrf_we     <= nxt_vrf_we;
            acc_clr    <= nxt_acc_clr;
            acc_en     <= nxt_acc_en;
            mem_req    <= nxt_mem_req;
            mem_we     <= nxt_mem_we;
            illegal_op <= nxt_illegal;
        end
    end

endmodule

// File: tb/tb_vpu_sequencer.sv
// Self-checking bench for vpu_sequencer: per-instruction cycle traces are
// captured as bit masks and compared against hand-derived expectations.
module tb_vpu_sequencer;
    import vpu_pkg::*;

    localparam int unsigned VEC_LEN = 4;
    localparam int unsigned LANE_W  = 2;
    localparam int unsigned MUL_LAT = 3;
    localparam int          MAX_CYC = 60;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              VPU_start;
    logic [4:0]        opcode;
    logic              x_bit;
    logic              mem_ack;
    logic              VPU_rdy;
    logic [LANE_W-1:0] lane_idx;
    logic              vrf_re, vrf_we;
    logic [2:0]        alu_op;
    logic              op_x, acc_clr, acc_en, mem_req, mem_we, illegal_op;

    vpu_sequencer #(
        .VEC_LEN (VEC_LEN),
        .LANE_W  (LANE_W),
        .MUL_LAT (MUL_LAT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .VPU_start  (VPU_start),
        .opcode     (opcode),
        .x_bit      (x_bit),
        .mem_ack    (mem_ack),
        .VPU_rdy    (VPU_rdy),
        .lane_idx   (lane_idx),
        .vrf_re     (vrf_re),
        .vrf_we     (vrf_we),
        .alu_op     (alu_op),
        .op_x       (op_x),
        .acc_clr    (acc_clr),
        .acc_en     (acc_en),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .illegal_op (illegal_op)
    );

    always #5 clk = ~clk;

    // One instruction: stimulus knobs plus the expected per-cycle masks (bit t = cycle Tt).
    typedef struct {
        logic [4:0]  op;
        logic        x;
        int          gap;
        int          ack_lane;
        int          ack_delay;
        bit          stray;
        int          done;
        logic [63:0] re, we, mr, mw, clr, en, ill;
        logic [7:0]  lre, lwe;
    } vec_t;

    vec_t tbl[10];
    vec_t sbq[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic vec_t mk(input logic [4:0] op, input logic x, input int gap,
                                input int ack_lane, input int ack_delay, input bit stray,
                                input int done, input logic [63:0] re, input logic [63:0] we,
                                input logic [63:0] mr, input logic [63:0] mw,
                                input logic [63:0] clr, input logic [63:0] en,
                                input logic [63:0] ill, input logic [7:0] lre,
                                input logic [7:0] lwe);
        vec_t v;
        v.op = op; v.x = x; v.gap = gap; v.ack_lane = ack_lane; v.ack_delay = ack_delay;
        v.stray = stray; v.done = done; v.re = re; v.we = we; v.mr = mr; v.mw = mw;
        v.clr = clr; v.en = en; v.ill = ill; v.lre = lre; v.lwe = lwe;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Issue one instruction at T0 (entered at posedge+1), hold start until DONE.
    task automatic run_op(input vec_t v);
        logic [63:0] rdy_m, re_m, we_m, mr_m, mw_m, clr_m, en_m, ill_m;
        logic [7:0]  lre_t, lwe_t;
        logic [2:0]  alu_s;
        logic        x_s;
        int          t, done, mcnt;
        vec_t        e;
        string       tag;

        if (v.gap > 0) begin
            VPU_start = 1'b0;
            repeat (v.gap) @(posedge clk);
            #1;
        end
        sbq.push_back(v);
        rdy_m = '0; re_m = '0; we_m = '0; mr_m = '0; mw_m = '0;
        clr_m = '0; en_m = '0; ill_m = '0; lre_t = '0; lwe_t = '0;
        alu_s = '0; x_s = 1'b0;
        t = 0; done = -1; mcnt = 0;

        while (done < 0 && t < MAX_CYC) begin
            VPU_start = 1'b1;
            opcode    = v.op;
            x_bit     = v.x;
            if (mem_req) begin
                if (int'(lane_idx) == v.ack_lane && mcnt < v.ack_delay) begin
                    mem_ack = 1'b0;
                    mcnt++;
                end else begin
                    mem_ack = 1'b1;
                end
            end else begin
                mem_ack = v.stray;
            end
            @(negedge clk);
            if (VPU_rdy)    rdy_m[6'(t)] = 1'b1;
            if (vrf_re) begin
                re_m[6'(t)] = 1'b1;
                lre_t = {lre_t[5:0], lane_idx};
            end
            if (vrf_we) begin
                we_m[6'(t)] = 1'b1;
                lwe_t = {lwe_t[5:0], lane_idx};
            end
            if (mem_req)    mr_m[6'(t)]  = 1'b1;
            if (mem_we)     mw_m[6'(t)]  = 1'b1;
            if (acc_clr)    clr_m[6'(t)] = 1'b1;
            if (acc_en)     en_m[6'(t)]  = 1'b1;
            if (illegal_op) ill_m[6'(t)] = 1'b1;
            if (t == 1) begin
                alu_s = alu_op;
                x_s   = op_x;
            end
            if (VPU_rdy && t > 0) done = t;
            @(posedge clk);
            #1;
            t++;
        end
        mem_ack = 1'b0;

        e   = sbq.pop_front();
        tag = $sformatf("op%b", e.op);
        if (done < 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s timeout: no DONE within %0d cycles", tag, MAX_CYC);
        end
        chk({tag, " rdy"},     rdy_m, 64'(1) << e.done);
        chk({tag, " vrf_re"},  re_m,  e.re);
        chk({tag, " vrf_we"},  we_m,  e.we);
        chk({tag, " mem_req"}, mr_m,  e.mr);
        chk({tag, " mem_we"},  mw_m,  e.mw);
        chk({tag, " acc_clr"}, clr_m, e.clr);
        chk({tag, " acc_en"},  en_m,  e.en);
        chk({tag, " illegal"}, ill_m, e.ill);
        chk({tag, " lane@re"}, 64'(lre_t), 64'(e.lre));
        chk({tag, " lane@we"}, 64'(lwe_t), 64'(e.lwe));
        chk({tag, " alu_op"},  64'(alu_s), 64'(e.op[2:0]));
        chk({tag, " op_x"},    64'(x_s),   64'(e.x));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;

        //            op       x gap lane dly str done  re        we         mr       mw       clr  en     ill  lre   lwe
        tbl[0] = mk(OP_VADD,   0, 1, -1, 0, 0, 13, 'h492,   'h1248,   0,       0,       0,   0,     0,   'h1B, 'h1B);
        tbl[1] = mk(OP_VSUB,   1, 1, -1, 0, 0, 13, 'h492,   'h1248,   0,       0,       0,   0,     0,   'h1B, 'h1B);
        tbl[2] = mk(OP_VMUL,   0, 1, -1, 0, 0, 21, 'h10842, 'h108420, 0,       0,       0,   0,     0,   'h1B, 'h1B);
        tbl[3] = mk(OP_VDOT,   1, 1, -1, 0, 0, 10, 'hAA,    'h200,    0,       0,       'h2, 'h154, 0,   'h1B, 'h03);
        tbl[4] = mk(OP_VLD,    0, 1, -1, 0, 0, 13, 'h492,   'h1248,   'h924,   0,       0,   0,     0,   'h1B, 'h1B);
        tbl[5] = mk(OP_VST,    0, 1, -1, 0, 0, 9,  'hAA,    0,        'h154,   'h154,   0,   0,     0,   'h1B, 0);
        tbl[6] = mk(OP_VST,    1, 1, 1,  4, 1, 13, 'hA0A,   0,        'h15F4,  'h15F4,  0,   0,     0,   'h1B, 0);
        tbl[7] = mk(5'b10110,  0, 1, -1, 0, 0, 1,  0,       0,        0,       0,       0,   0,     'h2, 0,    0);
        tbl[8] = mk(OP_VADD,   0, 0, -1, 0, 0, 13, 'h492,   'h1248,   0,       0,       0,   0,     0,   'h1B, 'h1B);
        tbl[9] = mk(OP_VLD,    0, 1, 2,  2, 0, 15, 'h1092,  'h4848,   'h2724,  0,       0,   0,     0,   'h1B, 'h1B);

        // Reset state, with and without a pending request.
        rst_n = 1'b0; VPU_start = 1'b0; opcode = '0; x_bit = 1'b0; mem_ack = 1'b0;
        #2;
        chk("reset rdy idle", 64'(VPU_rdy), 64'(1));
        chk("reset outputs", 64'({vrf_re, vrf_we, acc_clr, acc_en, mem_req, mem_we, illegal_op, op_x}), 64'(0));
        chk("reset lane/alu", 64'({lane_idx, alu_op}), 64'(0));
        VPU_start = 1'b1;
        #1;
        chk("reset rdy start", 64'(VPU_rdy), 64'(0));
        VPU_start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Table-driven instructions; entry 8 follows the illegal op back-to-back.
        foreach (tbl[i]) run_op(tbl[i]);

        // Asynchronous reset while VLD is stalled in MEM on lane 2.
        VPU_start = 1'b0;
        @(posedge clk);
        #1;
        n = 0;
        VPU_start = 1'b1; opcode = OP_VLD; x_bit = 1'b1;
        while (!(mem_req && lane_idx == 2'd2) && n < 40) begin
            mem_ack = mem_req && (lane_idx != 2'd2);
            @(posedge clk);
            #1;
            n++;
        end
        mem_ack = 1'b0;
        chk("midrst reached lane2 MEM", 64'({mem_req, lane_idx}), 64'({1'b1, 2'd2}));
        rst_n = 1'b0;
        #1;
        chk("midrst mem_req", 64'({mem_req, mem_we}), 64'(0));
        chk("midrst lane/alu/x", 64'({lane_idx, alu_op, op_x}), 64'(0));
        chk("midrst rdy start", 64'(VPU_rdy), 64'(0));
        VPU_start = 1'b0;
        #1;
        chk("midrst rdy idle", 64'(VPU_rdy), 64'(1));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_op(tbl[0]);
        run_op(tbl[3]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vpu_sequencer.md
Name: vpu_sequencer

Overview:
- VPU-side responder to the CPU control unit's VPU_start/VPU_rdy handshake.
- Accepts one VPU instruction, whose opcode has bit 4 set (excluding 5'b11111), and holds VPU_rdy low while busy.
- Steps a lane counter through READ/EXEC/MEM/WB phases, driving the vector register file, lane datapath and data-memory port.
- Returns VPU_rdy high for exactly one DONE cycle so the CPU advances without re-triggering.

Parameters:
- VEC_LEN, 4: elements per vector; one pass per element. Minimum 1.
- LANE_W, 2: width of lane_idx; equals clog2(VEC_LEN), minimum 1.
- MUL_LAT, 3: EXEC cycles per element for VMUL. Minimum 1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset
- VPU_start  in  1  CPU requests VPU instruction; held high while CPU is stalled
- opcode  in  5  instruction opcode; sampled only on accept
- x_bit  in  1  extra opcode bit; sampled on accept
- mem_ack  in  1  data memory completed current request
- VPU_rdy  out  1  VPU can accept or has completed; CPU stalls while low
- lane_idx  out  LANE_W  current element index
- vrf_re  out  1  vector register file read, current lane
- vrf_we  out  1  vector register file write, current lane
- alu_op  out  3  latched opcode[2:0] to lane datapath
- op_x  out  1  latched x_bit
- acc_clr  out  1  clear dot-product accumulator
- acc_en  out  1  accumulate lane product
- mem_req  out  1  data memory request, held until mem_ack
- mem_we  out  1  qualifies mem_req as store
- illegal_op  out  1  one-cycle pulse, unsupported VPU opcode

Behaviour:
- Clock and reset: one clock clk; reset rst_n is asynchronous, active-low.
- Reset, including mid-operation: state=IDLE, lane_idx=0, latched opcode and x_bit=0, any cycle counter=0. All Moore outputs are 0. VPU_rdy = ~VPU_start.
- Opcode map:
  - VADD 10000, VSUB 10001, VMUL 10010: element-wise.
  - VDOT 10011: reduction.
  - VLD 10100, VST 10101: memory.
  - Other opcodes 1xxxx except 11111: illegal.
  - Opcode 11111 and 0xxxx: never accepted; VPU_start must be low for them.
- VPU_rdy (combinational) = (state==IDLE & ~VPU_start) | state==DONE. It drops in the same cycle a request appears.
- Accept: in IDLE with VPU_start=1, latch opcode and x_bit, lane_idx<=0, go to READ. For an illegal opcode, go straight to DONE.
- VPU_start is ignored in every state except IDLE, including DONE. The held start of a completed instruction never re-triggers.
- States: IDLE, READ, EXEC, MEM, WB, DONE.
  - READ: vrf_re=1 for one cycle. acc_clr=1 when the opcode is VDOT and lane_idx=0. Next state is MEM for VLD/VST, otherwise EXEC.
  - EXEC: 1 cycle for VADD/VSUB/VDOT; MUL_LAT cycles for VMUL, using an internal down-counter. acc_en=1 in every EXEC cycle of VDOT. Then go to WB, except VDOT on a non-final lane, which advances to the next lane's READ.
  - MEM: mem_req=1 each cycle; mem_we=1 for VST. On the cycle mem_ack=1: VLD goes to WB; VST advances lane, or goes to DONE on the final lane. mem_ack outside MEM is ignored. No timeout.
  - WB: vrf_we=1 for one cycle. If lane_idx==VEC_LEN-1, go to DONE; else lane_idx+1 and go to READ.
  - DONE: one cycle, then IDLE. illegal_op=1 in DONE only when the latched opcode is illegal.
- Lane counter: lane_idx does not wrap during an instruction and returns to 0 on accept.
- Latency, counted from accept cycle T0 with immediate mem_ack, gives DONE (VPU_rdy=1) at:
  - VADD/VSUB: T(3·VEC_LEN+1).
  - VMUL: T((2+MUL_LAT)·VEC_LEN+1).
  - VDOT: T(2·VEC_LEN+2).
  - VLD: T(3·VEC_LEN+1).
  - VST: T(2·VEC_LEN+1).
  - Illegal: T1.
- Back-to-back instructions: when VPU_start stays high after DONE (next instruction), IDLE accepts it on the following cycle.

Decomposition:
- Package vpu_pkg holds:
  - VPU opcode localparams (VADD..VST).
  - State encoding typedef.
  - An is_vpu_legal opcode decode function.
- One sub-module, vpu_lane_counter: lane_idx register plus the EXEC down-counter (load, decrement, done flag).
- FSM stays in vpu_sequencer.

Test Plan:
- Reset, then VPU_start=1 with opcode=10000 at T0 -> VPU_rdy=0 at T0; lane_idx steps 0,1,2,3; vrf_re at T1,T4,T7,T10; vrf_we at T3,T6,T9,T12; VPU_rdy=1 only at T13.
- VMUL (10010), MUL_LAT=3 -> 3 EXEC cycles per lane, vrf_we at T5,T10,T15,T20, DONE at T21.
- VDOT (10011) -> acc_clr only at T1, acc_en at T2,T4,T6,T8, single vrf_we at T9 with lane_idx=3, DONE at T10.
- VST with mem_ack delayed 4 cycles on lane 1 -> mem_req/mem_we held through the stall, lane_idx stays 1, DONE delayed by exactly 4 cycles; a stray mem_ack in READ is ignored.
- Opcode 10110 -> illegal_op=1 and VPU_rdy=1 at T1; VPU_start held high through T1 is not re-accepted; a new opcode at T2 is accepted.
- rst_n low during VLD MEM phase -> mem_req=0 immediately (asynchronous), IDLE, lane_idx=0; after release, next VPU_start is accepted normally.
